// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the write-back register file.
//   - default geometry (register count, data width, address width)
//   - clear-sweep FSM state type
//   - index of the hardwired zero register
package regfile_pkg;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_ADDR_W   = 5;

  localparam int ZERO_REG = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: post-reset clear sweep sequencer for regfile_wb.
// Walks clr_idx from 0 to NUM_REGS-1, one register per cycle, then parks
// in RUN. Reset (synchronous, active-high) restarts the sweep at index 0
// and holds it there for as long as rst stays high.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   busy     out  high while the sweep is running (state CLEAR)
//   clr_we   out  clear-write strobe for mem[clr_idx]
//   clr_idx  out  register index being cleared this cycle
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    if (state_reg == ST_CLEAR) begin
      if (clr_idx_reg == LAST_IDX) begin
        // Leave before the index could wrap; park it at 0.
        state_next   = ST_RUN;
        clr_idx_next = '0;
      end else begin
        clr_idx_next = clr_idx_reg + 1'b1;
      end
    end
  end

  assign busy    = (state_reg == ST_CLEAR);
  assign clr_we  = (state_reg == ST_CLEAR);
  assign clr_idx = clr_idx_reg;

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: write-back register file with two combinational read ports.
// After reset a clear sweep zeroes every register; while it runs busy=1,
// reads return 0 and normal writes are dropped. Register 0 always reads 0.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read of the
// register being written in the same cycle returns write_data.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   rs_addr, rt_addr       read port A / B addresses
//   rd_addr                write address
//   write_data, reg_write  write-back value and its enable
//   rs_data, rt_data       read port A / B data
//   busy                   clear sweep in progress
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              run_we;

  logic [DATA_W-1:0] mem [NUM_REGS];

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Normal writes only outside the sweep and never to the zero register.
  assign run_we = reg_write && !busy && (rd_addr != ZERO_ADDR);

  // Sweep has priority; run_we is already masked by busy, so the else
  // branch only guards against any future loosening of that mask.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (run_we) begin
      mem[rd_addr] <= write_data;
    end
  end

  logic [ADDR_W-1:0] port_addr [2];
  logic [DATA_W-1:0] port_data [2];

  assign port_addr[0] = rs_addr;
  assign port_addr[1] = rt_addr;
  assign rs_data      = port_data[0];
  assign rt_data      = port_data[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        port_data[gi] = mem[port_addr[gi]];
`ifdef REGFILE_BYPASS_EN
        if (run_we && (port_addr[gi] == rd_addr)) begin
          port_data[gi] = write_data;
        end
`endif
        if (busy || (port_addr[gi] == ZERO_ADDR)) begin
          port_data[gi] = '0;
        end
      end
    end
  endgenerate

endmodule
